// File: rtl/sdram_wb_pipe_pkg.sv
// Shared definitions for the pipelined Wishbone front-end of the SDRAM driver:
// FSM encoding, counter width and command record layout.
package sdram_wb_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Holds any outstanding-request limit up to 255.
    localparam int CNT_W = 8;

    // Command record is packed as {addr, wr_rdn, wr_data, wr_mask}.
    function automatic int cmd_width(input int addr_w, input int data_w);
        return addr_w + 1 + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/sdram_wb_pipe_if.sv
// Classic-pipelined Wishbone slave bus carried between the interconnect and
// the SDRAM front-end.
interface sdram_wb_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wbs_address;
    logic [DATA_W-1:0] wbs_writedata;
    logic [SEL_W-1:0]  wbs_sel;
    logic              wbs_write;
    logic              wbs_strobe;
    logic              wbs_cycle;
    logic              wbs_stall;
    logic              wbs_ack;
    logic              wbs_err;
    logic [DATA_W-1:0] wbs_readdata;

    modport master (
        output wbs_address, wbs_writedata, wbs_sel, wbs_write, wbs_strobe, wbs_cycle,
        input  wbs_stall, wbs_ack, wbs_err, wbs_readdata
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_sel, wbs_write, wbs_strobe, wbs_cycle,
        output wbs_stall, wbs_ack, wbs_err, wbs_readdata
    );
endinterface

// File: rtl/sdram_wb_pipe_fifo.sv
// Synchronous command FIFO with a flush input; head entry is presented
// combinationally from the read pointer.
module sdram_wb_pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sdram_wb_pipe.sv
// Pipelined Wishbone slave front-end: queues requests for the SDRAM engine and
// returns ack/err/read data in request order, draining silently on an abort.
module sdram_wb_pipe
    import sdram_wb_pipe_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 16,
    parameter  int CMD_DEPTH = 8,
    parameter  int MAX_OUT   = 8,
    localparam int SEL_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    sdram_wb_pipe_if.slave    wbs,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_wr_rdn,
    output logic [DATA_W-1:0] sdram_wr_data,
    output logic [SEL_W-1:0]  sdram_wr_mask,
    output logic              sdram_cmd_rdy,
    input  logic              sdram_cmd_accepted,
    input  logic              sdram_cmd_done,
    input  logic [DATA_W-1:0] sdram_rd_data,
    input  logic              sdram_err,
    output logic              sdram_access
);
    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CMD_W-1:0]  cmd_push, cmd_head;
    logic              fifo_full, fifo_empty;
    logic              accept, pop, done_ok, flush, stall;
    logic              ack_p1, err_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Stall uses pre-pop fullness so a same-cycle pop never admits a push.
    assign stall         = fifo_full | (outstanding_q == MAX_OUT_C) | (state_q == ST_DRAIN);
    assign accept        = wbs.wbs_cycle & wbs.wbs_strobe & ~stall;
    assign sdram_cmd_rdy = ~fifo_empty & (state_q != ST_DRAIN);
    assign pop           = sdram_cmd_accepted & sdram_cmd_rdy;
    assign done_ok       = sdram_cmd_done & (inflight_q != '0);
    assign sdram_access  = (state_q != ST_IDLE) | wbs.wbs_cycle;

    assign cmd_push = {wbs.wbs_address, wbs.wbs_write, wbs.wbs_writedata, ~wbs.wbs_sel};
    assign {sdram_addr, sdram_wr_rdn, sdram_wr_data, sdram_wr_mask} = cmd_head;

    sdram_wb_pipe_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (accept),
        .pop     (pop),
        .wr_data (cmd_push),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        flush         = 1'b0;
        inflight_d    = inflight_q + CNT_W'(pop) - CNT_W'(done_ok);
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(done_ok);
        case (state_q)
            ST_IDLE: begin
                if (wbs.wbs_cycle) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!wbs.wbs_cycle) begin
                    if (outstanding_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Abort: queued work is dropped, only in-flight commands remain owed.
                        state_d       = ST_DRAIN;
                        flush         = 1'b1;
                        outstanding_d = inflight_d;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            outstanding_q <= '0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
        end
    end

    // Stage p1: completion registered one cycle after sdram_cmd_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            ack_p1 <= done_ok & ~sdram_err & (state_q != ST_DRAIN);
            err_p1 <= done_ok & sdram_err & (state_q != ST_DRAIN);
            if (done_ok) rdata_p1 <= sdram_rd_data;
        end
    end

    assign wbs.wbs_stall    = stall;
    assign wbs.wbs_ack      = ack_p1;
    assign wbs.wbs_err      = err_p1;
    assign wbs.wbs_readdata = rdata_p1;

endmodule

// File: tb/tb_sdram_wb_pipe.sv
// Bench for sdram_wb_pipe: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_sdram_wb_pipe;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 16;
    localparam int CMD_DEPTH = 4;
    localparam int MAX_OUT   = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sdram_addr;
    logic        sdram_wr_rdn;
    logic [15:0] sdram_wr_data;
    logic [1:0]  sdram_wr_mask;
    logic        sdram_cmd_rdy;
    logic        sdram_cmd_accepted;
    logic        sdram_cmd_done;
    logic [15:0] sdram_rd_data;
    logic        sdram_err;
    logic        sdram_access;

    int vectors     = 0;
    int miscompares = 0;

    sdram_wb_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_wb_pipe #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CMD_DEPTH (CMD_DEPTH),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .wbs                (bus),
        .sdram_addr         (sdram_addr),
        .sdram_wr_rdn       (sdram_wr_rdn),
        .sdram_wr_data      (sdram_wr_data),
        .sdram_wr_mask      (sdram_wr_mask),
        .sdram_cmd_rdy      (sdram_cmd_rdy),
        .sdram_cmd_accepted (sdram_cmd_accepted),
        .sdram_cmd_done     (sdram_cmd_done),
        .sdram_rd_data      (sdram_rd_data),
        .sdram_err          (sdram_err),
        .sdram_access       (sdram_access)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cse;   // {cycle, strobe, write}
        logic [31:0] a;
        logic [15:0] wd;
        logic [1:0]  sel;
        logic [2:0]  ade;   // {cmd_accepted, cmd_done, sdram_err}
        logic [15:0] rd;
        logic [4:0]  xs;    // expected {stall, cmd_rdy, ack, err, access}
        logic [15:0] xrd;
        logic [31:0] xa;
        logic        xw;
        logic [15:0] xwd;
        logic [1:0]  xm;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [15:0] d;
        logic [1:0]  m;
    } cmd_t;

    vec_t tbl [10];
    cmd_t q [$];
    cmd_t inf [$];

    function automatic vec_t row(input logic [2:0] cse, input logic [31:0] a, input logic [15:0] wd,
                                 input logic [1:0] sel, input logic [2:0] ade, input logic [15:0] rd,
                                 input logic [4:0] xs, input logic [15:0] xrd, input logic [31:0] xa,
                                 input logic xw, input logic [15:0] xwd, input logic [1:0] xm);
        vec_t r;
        r.cse = cse; r.a = a; r.wd = wd; r.sel = sel; r.ade = ade; r.rd = rd;
        r.xs = xs; r.xrd = xrd; r.xa = xa; r.xw = xw; r.xwd = xwd; r.xm = xm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic stall, input logic rdy, input logic ack,
                           input logic err, input logic access, input logic [15:0] rd);
        chk({tag, ".stall"},    32'(bus.wbs_stall),    32'(stall));
        chk({tag, ".cmd_rdy"},  32'(sdram_cmd_rdy),    32'(rdy));
        chk({tag, ".ack"},      32'(bus.wbs_ack),      32'(ack));
        chk({tag, ".err"},      32'(bus.wbs_err),      32'(err));
        chk({tag, ".access"},   32'(sdram_access),     32'(access));
        chk({tag, ".readdata"}, 32'(bus.wbs_readdata), 32'(rd));
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic w,
                            input logic [15:0] wd, input logic [1:0] m);
        chk({tag, ".addr"},    sdram_addr,            a);
        chk({tag, ".wr_rdn"},  32'(sdram_wr_rdn),     32'(w));
        chk({tag, ".wr_data"}, 32'(sdram_wr_data),    32'(wd));
        chk({tag, ".wr_mask"}, 32'(sdram_wr_mask),    32'(m));
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] a,
                         input logic [15:0] wd, input logic [1:0] sel, input logic acc,
                         input logic done, input logic err, input logic [15:0] rd);
        bus.wbs_cycle      = cyc;
        bus.wbs_strobe     = stb;
        bus.wbs_write      = we;
        bus.wbs_address    = a;
        bus.wbs_writedata  = wd;
        bus.wbs_sel        = sel;
        sdram_cmd_accepted = acc;
        sdram_cmd_done     = done;
        sdram_err          = err;
        sdram_rd_data      = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic        e_stall, stb, we, acc, done, err, draining;
        logic        exp_ack, exp_err;
        logic [15:0] exp_rd, rd;
        cmd_t        c;

        tbl[0] = row(3'b111, 32'h10, 16'hBEEF, 2'b11, 3'b000, 16'h0,    5'b00000, 16'h0,    32'h0,  1'b0, 16'h0,    2'b00);
        tbl[1] = row(3'b100, 32'h0,  16'h0,    2'b00, 3'b100, 16'h0,    5'b01001, 16'h0,    32'h10, 1'b1, 16'hBEEF, 2'b00);
        tbl[2] = row(3'b100, 32'h0,  16'h0,    2'b00, 3'b010, 16'h0,    5'b00001, 16'h0,    32'h0,  1'b0, 16'h0,    2'b00);
        tbl[3] = row(3'b110, 32'h20, 16'h0,    2'b01, 3'b000, 16'h0,    5'b00101, 16'h0,    32'h0,  1'b0, 16'h0,    2'b00);
        tbl[4] = row(3'b110, 32'h22, 16'h0,    2'b11, 3'b100, 16'h0,    5'b01001, 16'h0,    32'h20, 1'b0, 16'h0,    2'b10);
        tbl[5] = row(3'b110, 32'h24, 16'h0,    2'b10, 3'b110, 16'h1111, 5'b01001, 16'h0,    32'h22, 1'b0, 16'h0,    2'b00);
        tbl[6] = row(3'b100, 32'h0,  16'h0,    2'b00, 3'b111, 16'h2222, 5'b01101, 16'h1111, 32'h24, 1'b0, 16'h0,    2'b01);
        tbl[7] = row(3'b100, 32'h0,  16'h0,    2'b00, 3'b010, 16'h3333, 5'b00011, 16'h2222, 32'h0,  1'b0, 16'h0,    2'b00);
        tbl[8] = row(3'b000, 32'h0,  16'h0,    2'b00, 3'b010, 16'h4444, 5'b00101, 16'h3333, 32'h0,  1'b0, 16'h0,    2'b00);
        tbl[9] = row(3'b000, 32'h0,  16'h0,    2'b00, 3'b000, 16'h0,    5'b00000, 16'h3333, 32'h0,  1'b0, 16'h0,    2'b00);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Single write, then three reads with an error on the middle one.
        for (int i = 0; i < 10; i++) begin
            chk_out($sformatf("tbl%0d", i), tbl[i].xs[4], tbl[i].xs[3], tbl[i].xs[2],
                    tbl[i].xs[1], tbl[i].xs[0], tbl[i].xrd);
            if (tbl[i].xs[3])
                chk_head($sformatf("tbl%0d", i), tbl[i].xa, tbl[i].xw, tbl[i].xwd, tbl[i].xm);
            drive(tbl[i].cse[2], tbl[i].cse[1], tbl[i].cse[0], tbl[i].a, tbl[i].wd, tbl[i].sel,
                  tbl[i].ade[2], tbl[i].ade[1], tbl[i].ade[0], tbl[i].rd);
            step();
        end

        // Eight pipelined reads, controller accepts one per cycle.
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("burst%0d.stall", k), 32'(bus.wbs_stall), 32'd0);
            chk($sformatf("burst%0d.ack", k), 32'(bus.wbs_ack), 32'((k >= 3) && (k <= 10)));
            if (k >= 3 && k <= 10)
                chk($sformatf("burst%0d.readdata", k), 32'(bus.wbs_readdata), 32'h1000 + 32'(k - 3));
            drive(k < 11, k < 8, 1'b0, 32'h100 + 32'(2 * k), 16'h0, 2'b11,
                  (k >= 1) && (k <= 8), (k >= 2) && (k <= 9), 1'b0, 16'h1000 + 16'(k - 2));
            step();
        end

        // Abort with 3 queued and 2 in flight.
        for (int k = 0; k < 13; k++) begin
            case (k)
                0, 1, 2, 3, 4: begin
                    chk($sformatf("drain%0d.stall", k), 32'(bus.wbs_stall), 32'd0);
                    drive(1'b1, 1'b1, 1'b0, 32'h300 + 32'(2 * k), 16'h0, 2'b11,
                          (k == 1) || (k == 2), 1'b0, 1'b0, 16'h0);
                end
                5: begin
                    chk("drain5.cmd_rdy", 32'(sdram_cmd_rdy), 32'd1);
                    chk("drain5.addr", sdram_addr, 32'h304);
                    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
                end
                6: begin
                    chk_out("drain6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1007);
                    drive(1'b1, 1'b1, 1'b1, 32'h500, 16'h5555, 2'b11, 1'b1, 1'b1, 1'b0, 16'hDEAD);
                end
                7: begin
                    chk_out("drain7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
                    drive(1'b1, 1'b1, 1'b1, 32'h502, 16'h5555, 2'b11, 1'b1, 1'b1, 1'b1, 16'hBEAD);
                end
                8: begin
                    chk_out("drain8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEAD);
                    drive(1'b1, 1'b1, 1'b1, 32'h400, 16'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0);
                end
                9: begin
                    chk("drain9.stall", 32'(bus.wbs_stall), 32'd0);
                    chk("drain9.cmd_rdy", 32'(sdram_cmd_rdy), 32'd1);
                    chk_head("drain9", 32'h400, 1'b1, 16'h1234, 2'b10);
                    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0);
                end
                10: begin
                    chk("drain10.cmd_rdy", 32'(sdram_cmd_rdy), 32'd0);
                    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0);
                end
                11: begin
                    chk("drain11.ack", 32'(bus.wbs_ack), 32'd1);
                    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
                end
                default: begin
                    chk_out("drain12", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
                end
            endcase
            if (k < 12) step();
        end

        // Outstanding limit, then reset with 5 requests outstanding.
        for (int k = 0; k < 12; k++) begin
            chk_out($sformatf("limit%0d", k),
                    (k == 6) || (k == 7) || (k == 9) || (k == 10),
                    ((k >= 1) && (k <= 6)) || (k == 9),
                    (k == 8) || (k == 11), 1'b0, k != 0,
                    (k >= 11) ? 16'h5555 : ((k >= 8) ? 16'hABCD : 16'h0));
            if (k < 11)
                drive(1'b1, 1'b1, 1'b1, 32'h200 + 32'(k), 16'(k), 2'b11, 1'b1,
                      (k == 7) || (k == 10), 1'b0, (k == 7) ? 16'hABCD : 16'h5555);
            step();
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h7777);
        step();
        chk_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h9999);
        step();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        step();

        // Randomized traffic with the bus cycle held, checked against a queue model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_rd  = 16'h0;
        for (int n = 0; n < 3040; n++) begin
            draining = (n >= 3000);
            e_stall = (q.size() == CMD_DEPTH) || (q.size() + inf.size() == MAX_OUT);
            chk($sformatf("rnd%0d.stall", n), 32'(bus.wbs_stall), 32'(e_stall));
            chk($sformatf("rnd%0d.cmd_rdy", n), 32'(sdram_cmd_rdy), 32'(q.size() != 0));
            chk($sformatf("rnd%0d.ack", n), 32'(bus.wbs_ack), 32'(exp_ack));
            chk($sformatf("rnd%0d.err", n), 32'(bus.wbs_err), 32'(exp_err));
            chk($sformatf("rnd%0d.readdata", n), 32'(bus.wbs_readdata), 32'(exp_rd));
            if (q.size() != 0)
                chk_head($sformatf("rnd%0d", n), q[0].a, q[0].w, q[0].d, q[0].m);

            stb  = !draining && ($urandom_range(0, 9) < 7);
            we   = 1'($urandom);
            acc  = draining || ($urandom_range(0, 1) == 1);
            done = draining || ($urandom_range(0, 1) == 1);
            err  = ($urandom_range(0, 3) == 0);
            rd   = 16'($urandom);
            c.a  = $urandom;
            c.w  = we;
            c.d  = 16'($urandom);
            c.m  = 2'($urandom);
            drive(1'b1, stb, we, c.a, c.d, ~c.m, acc, done, err, rd);

            exp_ack = 1'b0;
            exp_err = 1'b0;
            if (done && inf.size() > 0) begin
                void'(inf.pop_front());
                exp_ack = !err;
                exp_err = err;
                exp_rd  = rd;
            end
            if (acc && q.size() > 0) inf.push_back(q.pop_front());
            if (stb && !e_stall) q.push_back(c);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        chk_out("rnd_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_wb_pipe.md
# sdram_wb_pipe

Pipelined Wishbone slave front-end for the SDRAM driver, generalised in address/data width, command-queue depth and outstanding-transaction limit. Accepts classic-pipelined Wishbone requests with byte selects, queues them, presents them one at a time to the SDRAM controller, and returns acks, read data and errors in request order. Also handles a Wishbone cycle aborted mid-burst by flushing queued work and draining in-flight commands silently. Sits between the system Wishbone interconnect and the SDRAM command/data engine.

## Interface
- ADDR_W, 32, Wishbone/SDRAM byte address width
- DATA_W, 16, data width; multiple of 8
- SEL_W, DATA_W/8, byte-select width (derived, do not override)
- CMD_DEPTH, 8, command FIFO depth; power of 2, ≥2
- MAX_OUT, 8, max requests accepted but not yet acked (queued + in flight); 1..255
---
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wbs_address  in  ADDR_W  request address
- wbs_writedata  in  DATA_W  write data
- wbs_sel  in  SEL_W  byte enables, 1 = byte written
- wbs_write  in  1  1 = write, 0 = read
- wbs_strobe  in  1  request valid
- wbs_cycle  in  1  bus cycle active
- wbs_stall  out  1  request not accepted this cycle
- wbs_ack  out  1  request completed OK (registered)
- wbs_err  out  1  request completed with error (registered)
- wbs_readdata  out  DATA_W  read data, valid with wbs_ack on reads
- sdram_addr  out  ADDR_W  head command address
- sdram_wr_rdn  out  1  head command: 1 = write
- sdram_wr_data  out  DATA_W  head command write data
- sdram_wr_mask  out  SEL_W  head command byte mask, 1 = masked (= ~sel)
- sdram_cmd_rdy  out  1  command FIFO non-empty
- sdram_cmd_accepted  in  1  controller takes head command (pops FIFO)
- sdram_cmd_done  in  1  oldest in-flight command finished
- sdram_rd_data  in  DATA_W  read data, valid with sdram_cmd_done
- sdram_err  in  1  qualifies sdram_cmd_done as failed
- sdram_access  out  1  bus ownership request to SDRAM arbiter

## Operation
- Accept = wbs_cycle & wbs_strobe & ~wbs_stall & state==ACTIVE|IDLE; pushes {addr, write, data, ~sel}.
- wbs_stall = fifo_full | (outstanding == MAX_OUT) | state==DRAIN.
- outstanding: +1 on accept, −1 on sdram_cmd_done; simultaneous → unchanged. inflight: +1 on sdram_cmd_accepted, −1 on done.
- sdram_cmd_accepted while FIFO empty: ignored. sdram_cmd_done while inflight==0: ignored, no ack, counters do not underflow.
- wbs_ack <= done & ~err & state!=DRAIN; wbs_err <= done & err & state!=DRAIN; wbs_readdata <= sdram_rd_data on every done, else held.
- FSM: IDLE (outstanding 0, cycle low) → ACTIVE on wbs_cycle. ACTIVE → IDLE when cycle low and outstanding 0. ACTIVE → DRAIN when cycle drops with outstanding >0: FIFO flushed that cycle, outstanding := inflight, sdram_cmd_rdy forced 0. DRAIN → IDLE when inflight reaches 0 (including same-cycle final done); new cycle stalls until then.
- sdram_access = state!=IDLE | wbs_cycle.
- Reset values: wbs_ack 0, wbs_err 0, wbs_readdata 0, wbs_stall 0, sdram_cmd_rdy 0, sdram_access 0, counters 0, FIFO empty, state IDLE. Reset mid-transfer discards everything; no acks follow.

## Timing
- Accept cycle N → sdram_cmd_rdy and head fields valid in N+1 (if FIFO was empty).
- sdram_cmd_done in cycle M → wbs_ack/wbs_err/wbs_readdata in M+1, one-cycle pulse per done.
- Minimum strobe→ack latency: 2 cycles + controller latency; back-to-back dones give back-to-back acks.
- Stall is combinational from registered state/counters; a pop and push in one cycle on a full FIFO: push still stalled (stall uses pre-pop full).

## Structure
- Shared package/include sdram_defs: command record field layout and widths, FSM state encodings.
- Sub-module: existing syn_fifo (DATA_W = ADDR_W+1+DATA_W+SEL_W, depth CMD_DEPTH) plus a synchronous flush input added; counters and FSM live in top.

## Test plan
- Single write 0x0000_0010/0xBEEF, sel 2'b11 → cmd_rdy at N+1 with wr_mask 2'b00; done → one ack, readdata unchanged.
- 8 pipelined reads, controller accept 1/cycle, done with data 0x1000+i → 8 acks in order, readdata 0x1000..0x1007.
- MAX_OUT=4, controller stalled → stall asserts after 4th accept; one done → stall drops next cycle, 5th accepted.
- Done with sdram_err=1 on 2nd of 3 reads → ack, err, ack; never ack and err together.
- Cycle dropped with 3 queued, 2 in flight → FIFO flushed, cmd_rdy 0, 2 dones produce no ack, IDLE after 2nd; new cycle stalled until then.
- Reset asserted with 5 outstanding → next cycle all outputs at reset values; subsequent spurious done ignored.
